// File: rtl/acc_pkg.sv
// acc_pkg: opcodes, sequencer state encoding and defaults shared by the accumulator datapath
package acc_pkg;
    localparam logic [3:0] OP_BT   = 4'd7;
    localparam logic [3:0] OP_BF   = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam int DEF_MEM_TIMEOUT = 15;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALTED, ERR} seq_state_t;
    function automatic logic branchTaken(input logic [3:0] op, input logic cond);
        return (op == OP_BT && cond) || (op == OP_BF && !cond);
    endfunction
endpackage

// File: rtl/seq_mem_timer.sv
// seq_mem_timer: counts MEM cycles without an ack; expired flags the cycle that would reach TIMEOUT
module seq_mem_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) count <= '0;
        else if (load) count <= '0;
        else if (inc) count <= count + W'(1);
    assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/execute sequencer with memory handshake timeout, lookup branches, halt/restart.
// Define SEQ_PERF_EN to build the saturating instruction/cycle performance counters.
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    input  logic [3:0] OP,
    input  logic TypeBit,
    input  logic AWrite,
    input  logic RWrite,
    input  logic ReadMem,
    input  logic WriteMem,
    input  logic LookUp,
    input  logic Halt,
    input  logic Cond,
    input  logic MemAck,
    output logic IRLoad,
    output logic PCInc,
    output logic PCBranch,
    output logic PCClear,
    output logic MemReq,
    output logic MemWe,
    output logic AccWE,
    output logic RegWE,
    output logic Busy,
    output logic Done,
    output logic MemErr,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
);
    seq_state_t state, nextState;
    logic memWeQ, timerLoad, timerInc, expired;

    seq_mem_timer #(.TIMEOUT(MEM_TIMEOUT)) timer (
        .Clk(Clk), .Reset(Reset), .load(timerLoad), .inc(timerInc), .expired(expired)
    );

    always_comb begin
        nextState = state;
        {IRLoad, PCInc, PCBranch, PCClear, MemReq, MemWe, AccWE, RegWE, Done, MemErr} = '0;
        {timerLoad, timerInc} = '0;
        case (state)
            IDLE: if (Start) begin
                PCClear = 1'b1;
                nextState = FETCH;
            end
            FETCH: begin
                IRLoad = 1'b1;
                nextState = EXEC;
            end
            EXEC:
                if (Halt && TypeBit) nextState = HALTED;
                else if (ReadMem || WriteMem) begin
                    timerLoad = 1'b1;
                    nextState = MEM;
                end else if (LookUp) begin
                    PCBranch = branchTaken(OP, Cond);
                    PCInc = !PCBranch;
                    nextState = FETCH;
                end else begin
                    AccWE = AWrite;
                    RegWE = RWrite;
                    PCInc = 1'b1;
                    nextState = FETCH;
                end
            MEM: begin
                MemReq = 1'b1;
                MemWe = memWeQ;
                // an ack in the expiring cycle still completes the access
                if (MemAck) begin
                    AccWE = !memWeQ;
                    PCInc = 1'b1;
                    nextState = FETCH;
                end else if (expired) nextState = ERR;
                else timerInc = 1'b1;
            end
            HALTED, ERR: begin
                Done = 1'b1;
                MemErr = state == ERR;
                if (Start) begin
                    PCClear = 1'b1;
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign Busy = state == FETCH || state == EXEC || state == MEM;

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state <= IDLE;
            memWeQ <= 1'b0;
        end else begin
            state <= nextState;
            if (timerLoad) memWeQ <= WriteMem;
        end

`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] instrCnt, cycleCnt;
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            instrCnt <= '0;
            cycleCnt <= '0;
        end else if (PCClear) begin
            instrCnt <= '0;
            cycleCnt <= '0;
        end else begin
            if ((PCInc || PCBranch) && instrCnt != '1) instrCnt <= instrCnt + CNT_W'(1);
            if (Busy && cycleCnt != '1) cycleCnt <= cycleCnt + CNT_W'(1);
        end
    assign InstrCount = instrCnt;
    assign CycleCount = cycleCnt;
`else
    assign InstrCount = '0;
    assign CycleCount = '0;
`endif
endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the accumulator datapath.
- Consumes the instruction decoder's control bits, which are combinational from TypeBit/OP.
- Generates per-cycle enables for the instruction register, PC, register file, accumulator and data memory.
- Handles the memory request/acknowledge handshake with a timeout, taken/not-taken lookup branches, halt and restart.

Parameters:
- MEM_TIMEOUT, 15: max cycles MemReq may stay high without MemAck before error.
- CNT_W, 16: width of performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level/pulse; begins execution from PC 0.
- OP  in  4  opcode field of current IR (identifies bt=7 / bf=8).
- TypeBit  in  1  0 = geti immediate instruction.
- AWrite  in  1  decoder: accumulator write.
- RWrite  in  1  decoder: register write.
- ReadMem  in  1  decoder: load.
- WriteMem  in  1  decoder: store.
- LookUp  in  1  decoder: branch via lookup table.
- Halt  in  1  decoder: halt.
- Cond  in  1  accumulator bit 0, branch condition.
- MemAck  in  1  data memory completion strobe, one cycle.
- IRLoad  out  1  load IR from instruction memory.
- PCInc  out  1  PC <= PC+1.
- PCBranch  out  1  PC <= lookup table target.
- PCClear  out  1  PC <= 0.
- MemReq  out  1  data memory request, held until ack.
- MemWe  out  1  request is a store.
- AccWE  out  1  accumulator write enable.
- RegWE  out  1  register file write enable.
- Busy  out  1  not IDLE/HALTED/ERR.
- Done  out  1  HALTED or ERR.
- MemErr  out  1  sticky timeout flag.
- InstrCount  out  CNT_W  retired instructions (optional feature).
- CycleCount  out  CNT_W  busy cycles (optional feature).

Behaviour:
- Reset (async, any state, including mid-memory-request): state IDLE, all outputs 0, timeout counter 0, MemErr 0, counters 0.
- State register is updated on Clk. Outputs decode combinationally from state and decoder inputs; each enable is asserted for exactly one cycle unless stated otherwise.
- IDLE: Start=1 -> PCClear=1, go to FETCH.
- FETCH: IRLoad=1 -> EXEC.
- EXEC: decoder inputs are valid from the loaded IR. The first matching rule applies:
  - Halt=1 (and TypeBit=1) -> HALTED, no enables.
  - ReadMem or WriteMem -> MEM; latch MemWe=WriteMem; clear timeout counter.
  - LookUp: OP=7 and Cond=1, or OP=8 and Cond=0 -> PCBranch=1; otherwise PCInc=1. Then -> FETCH.
  - Otherwise: AccWE=AWrite, RegWE=RWrite, PCInc=1 -> FETCH.
- MEM: MemReq=1 and MemWe held stable.
  - On MemAck=1: AccWE=1 if load, PCInc=1, -> FETCH.
  - If no ack, the counter increments; at MEM_TIMEOUT -> ERR, MemErr=1.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins; no error is raised.
- Latency:
  - Non-memory instruction: 2 cycles.
  - Memory instruction: 3 + wait cycles. Ack in the first MEM cycle gives 3.
- HALTED: Done=1. Start=1 -> PCClear, FETCH; Done drops the next cycle.
- ERR: Done=1 and MemErr=1, sticky. Exit only by Start=1 (clears MemErr, PCClear, FETCH) or by reset.
- Start is ignored in FETCH, EXEC and MEM.
- MemAck outside MEM is ignored.

Optional Feature:
- SEQ_PERF_EN defined:
  - InstrCount increments on every PCInc/PCBranch.
  - CycleCount increments every Busy cycle.
  - Both saturate at all-ones and clear on Start out of IDLE/HALTED/ERR.
- Not defined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Shared package acc_pkg holds:
  - Opcode constants (OP_BT=7, OP_BF=8, OP_HALT=15, etc.).
  - seq_state_t enum: IDLE, FETCH, EXEC, MEM, HALTED, ERR.
  - Default MEM_TIMEOUT.
- Sub-module seq_mem_timer: load/increment/compare timeout counter with an expired output.

Test Plan:
- Reset low mid-MEM with MemReq=1 -> next edge all outputs 0, state IDLE, MemReq=0 without waiting for Clk.
- Start, instr add (AWrite=1) then halt -> cycle1 PCClear, cycle2 IRLoad, cycle3 AccWE+PCInc, cycle4 IRLoad, cycle5 enter HALTED; Done=1 from cycle6.
- lw with MemAck after 4 wait cycles -> MemReq high exactly 5 cycles, MemWe=0, AccWE+PCInc on the ack cycle.
- sw with no MemAck, MEM_TIMEOUT=15 -> MemReq high 15 cycles, then MemErr=1, Done=1; Start clears MemErr and restarts at PC 0.
- bt with Cond=1 -> PCBranch=1, PCInc=0; bt with Cond=0 -> PCInc=1. bf with Cond=0 -> PCBranch=1.
- SEQ_PERF_EN: 3 instructions then halt -> InstrCount=3; CycleCount equals the number of Busy cycles observed.
